// File: rtl/hotspot_pkg.sv
// hotspot_pkg: shared constants, FSM state type and pixel helpers for the
// hotspot locator. The HOTSPOT_SMOOTH_EN build uses smooth_step() to ease the
// sprite toward each new peak instead of jumping.
package hotspot_pkg;

    localparam int DEF_GRID_W = 16;
    localparam int DEF_GRID_H = 9;
    localparam int DEF_PWR_W  = 24;
    localparam int DEF_CELL_W = 30;
    localparam int DEF_CELL_H = 30;
    localparam int DEF_H_RES  = 480;
    localparam int DEF_V_RES  = 272;
    localparam int DEF_MARGIN = 24;
    localparam int SMOOTH_SH  = 2;

    localparam int N_CELLS = DEF_GRID_W * DEF_GRID_H;
    localparam int IDX_W   = $clog2(N_CELLS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_MAP
    } state_t;

    // Limit a signed pixel coordinate to [lo, hi] so the sprite stays on screen.
    function automatic logic [15:0] clamp_px(input logic signed [16:0] v,
                                             input int lo, input int hi);
        int vi;
        vi = int'(v);
        if (vi < lo)
            return 16'(lo);
        else if (vi > hi)
            return 16'(hi);
        else
            return v[15:0];
    endfunction

    // Move cur a fraction of the way toward tgt (signed 17-bit arithmetic).
    function automatic logic signed [16:0] smooth_step(input logic [15:0] cur,
                                                       input logic [15:0] tgt);
        logic signed [16:0] diff;
        diff = signed'({1'b0, tgt}) - signed'({1'b0, cur});
        return signed'({1'b0, cur}) + (diff >>> SMOOTH_SH);
    endfunction

endpackage

// File: rtl/hotspot_argmax.sv
// hotspot_argmax: running maximum over one raster scan of the steering grid.
// Tracks the position of the incoming sample and of the best sample so far;
// strict comparison means the first occurrence of a tied maximum is kept.
module hotspot_argmax
    import hotspot_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H,
    parameter int PWR_W  = DEF_PWR_W,
    parameter int CELLS  = N_CELLS,
    parameter int CNT_W  = IDX_W,
    localparam int COL_W = $clog2(GRID_W),
    localparam int ROW_W = $clog2(GRID_H)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_take,
    input  logic             i_frame_start,
    input  logic             i_scanning,
    input  logic [PWR_W-1:0] i_data,
    output logic             o_last,
    output logic             o_restart,
    output logic [PWR_W-1:0] o_max,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row
);

    logic [PWR_W-1:0] r_max;
    logic [COL_W-1:0] r_cur_col;
    logic [ROW_W-1:0] r_cur_row;
    logic [COL_W-1:0] r_best_col;
    logic [ROW_W-1:0] r_best_row;
    logic [CNT_W-1:0] r_cnt;

    logic w_start;
    logic w_step;

    assign w_start   = i_take & i_frame_start;
    assign w_step    = i_take & i_scanning & ~i_frame_start;
    assign o_restart = i_take & i_scanning & i_frame_start;
    assign o_last    = w_step & (r_cnt == CNT_W'(CELLS - 1));
    assign o_max     = r_max;
    assign o_col     = r_best_col;
    assign o_row     = r_best_row;

    // A frame_start transfer seeds the scan at index 0; later transfers update the max and advance the raster position.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_max      <= '0;
            r_cur_col  <= '0;
            r_cur_row  <= '0;
            r_best_col <= '0;
            r_best_row <= '0;
            r_cnt      <= '0;
        end else if (w_start) begin
            r_max      <= i_data;
            r_best_col <= '0;
            r_best_row <= '0;
            r_cur_col  <= COL_W'(1);
            r_cur_row  <= '0;
            r_cnt      <= CNT_W'(1);
        end else if (w_step) begin
            if (i_data > r_max) begin
                r_max      <= i_data;
                r_best_col <= r_cur_col;
                r_best_row <= r_cur_row;
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cur_col == COL_W'(GRID_W - 1)) begin
                r_cur_col <= '0;
                r_cur_row <= r_cur_row + ROW_W'(1);
            end else begin
                r_cur_col <= r_cur_col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/hotspot_locator.sv
// hotspot_locator: finds the peak cell of each power scan, maps it to a clamped
// sprite centre and presents it to the overlay only on a vsync rising edge.
// Optional macro HOTSPOT_SMOOTH_EN eases the sprite toward each new hit.
module hotspot_locator
    import hotspot_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H,
    parameter int PWR_W  = DEF_PWR_W,
    parameter int CELL_W = DEF_CELL_W,
    parameter int CELL_H = DEF_CELL_H,
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int MARGIN = DEF_MARGIN
) (
    input  logic             i_clk_pix,
    input  logic             i_rst,
    input  logic             i_frame_start,
    input  logic             i_pwr_valid,
    input  logic [PWR_W-1:0] i_pwr_data,
    output logic             o_pwr_ready,
    input  logic [PWR_W-1:0] i_min_pwr,
    input  logic             i_vsync,
    output logic [15:0]      o_pix_x,
    output logic [15:0]      o_pix_y,
    output logic             o_spot_valid,
    output logic [PWR_W-1:0] o_peak_pwr,
    output logic             o_scan_err
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int CNT_W = $clog2(CELLS);
    localparam int COL_W = $clog2(GRID_W);
    localparam int ROW_W = $clog2(GRID_H);
    localparam int X_MAX = H_RES - 1 - MARGIN;
    localparam int Y_MAX = V_RES - 1 - MARGIN;

    state_t           r_state;
    logic             r_ready;
    logic             r_vsync_d;
    logic             r_pend;
    logic [15:0]      r_stage_x;
    logic [15:0]      r_stage_y;
    logic [PWR_W-1:0] r_stage_max;
    logic             r_stage_hit;
    logic [15:0]      r_pix_x;
    logic [15:0]      r_pix_y;
    logic             r_spot_valid;
    logic [PWR_W-1:0] r_peak_pwr;
    logic             r_scan_err;
`ifdef HOTSPOT_SMOOTH_EN
    logic             r_seeded;
`endif

    logic             w_take;
    logic             w_last;
    logic             w_restart;
    logic [PWR_W-1:0] w_max;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [15:0]      w_x;
    logic [15:0]      w_y;
    logic [15:0]      w_x_cl;
    logic [15:0]      w_y_cl;
    logic             w_vs_rise;
    logic             w_update;

    assign w_take       = i_pwr_valid & r_ready;
    assign o_pwr_ready  = r_ready;
    assign o_pix_x      = r_pix_x;
    assign o_pix_y      = r_pix_y;
    assign o_spot_valid = r_spot_valid;
    assign o_peak_pwr   = r_peak_pwr;
    assign o_scan_err   = r_scan_err;

    hotspot_argmax #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .PWR_W  (PWR_W),
        .CELLS  (CELLS),
        .CNT_W  (CNT_W)
    ) u_argmax (
        .i_clk         (i_clk_pix),
        .i_rst         (i_rst),
        .i_take        (w_take),
        .i_frame_start (i_frame_start),
        .i_scanning    (r_state == ST_SCAN),
        .i_data        (i_pwr_data),
        .o_last        (w_last),
        .o_restart     (w_restart),
        .o_max         (w_max),
        .o_col         (w_col),
        .o_row         (w_row)
    );

    assign w_x       = 16'(w_col) * 16'(CELL_W) + 16'(CELL_W / 2);
    assign w_y       = 16'(w_row) * 16'(CELL_H) + 16'(CELL_H / 2);
    assign w_x_cl    = clamp_px(signed'({1'b0, w_x}), MARGIN, X_MAX);
    assign w_y_cl    = clamp_px(signed'({1'b0, w_y}), MARGIN, Y_MAX);
    assign w_vs_rise = i_vsync & ~r_vsync_d;
    assign w_update  = w_vs_rise & r_pend;

    // Scan sequencing: wait for a frame_start, count the scan, then spend one cycle in MAP with the input stalled.
    always_ff @(posedge i_clk_pix) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take && i_frame_start)
                        r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (w_last) begin
                        r_state <= ST_MAP;
                        r_ready <= 1'b0;
                    end
                end
                ST_MAP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stage each mapped result and release it to the overlay only on a vsync rising edge; a result staged in the same cycle waits for the next edge.
    always_ff @(posedge i_clk_pix) begin
        if (i_rst) begin
            r_vsync_d    <= 1'b0;
            r_pend       <= 1'b0;
            r_stage_x    <= '0;
            r_stage_y    <= '0;
            r_stage_max  <= '0;
            r_stage_hit  <= 1'b0;
            r_pix_x      <= 16'(H_RES / 2);
            r_pix_y      <= 16'(V_RES / 2);
            r_spot_valid <= 1'b0;
            r_peak_pwr   <= '0;
            r_scan_err   <= 1'b0;
`ifdef HOTSPOT_SMOOTH_EN
            r_seeded     <= 1'b0;
`endif
        end else begin
            r_vsync_d  <= i_vsync;
            r_scan_err <= w_restart;

            if (r_state == ST_MAP) begin
                r_stage_x   <= w_x_cl;
                r_stage_y   <= w_y_cl;
                r_stage_max <= w_max;
                r_stage_hit <= (w_max >= i_min_pwr);
                r_pend      <= 1'b1;
            end else if (w_update) begin
                r_pend <= 1'b0;
            end

            if (w_update) begin
                r_spot_valid <= r_stage_hit;
                r_peak_pwr   <= r_stage_max;
                if (r_stage_hit) begin
`ifdef HOTSPOT_SMOOTH_EN
                    if (r_seeded) begin
                        r_pix_x <= clamp_px(smooth_step(r_pix_x, r_stage_x), MARGIN, X_MAX);
                        r_pix_y <= clamp_px(smooth_step(r_pix_y, r_stage_y), MARGIN, Y_MAX);
                    end else begin
                        r_pix_x <= r_stage_x;
                        r_pix_y <= r_stage_y;
                    end
                    r_seeded <= 1'b1;
`else
                    r_pix_x <= r_stage_x;
                    r_pix_y <= r_stage_y;
`endif
                end
            end
        end
    end

endmodule

// File: doc/hotspot_locator.md
Name: hotspot_locator

Overview:
Upstream stage of the hotspot overlay. Consumes one scan of beamformed power values over a GRID_W x GRID_H steering grid and finds the peak cell (argmax). Maps that cell to a screen-pixel centre, clamped so the 49x49 sprite stays on screen. Presents pix_x/pix_y/spot_valid to the overlay, updated only at a display vsync rising edge so the sprite never tears mid-frame.

Parameters:
GRID_W, 16, steering grid columns
GRID_H, 9, steering grid rows
PWR_W, 24, power sample width (unsigned)
CELL_W, 30, pixels per grid column
CELL_H, 30, pixels per grid row
H_RES, 480, active display width
V_RES, 272, active display height
MARGIN, 24, sprite half-size (THD_SIZE-1)/2 used for clamping
SMOOTH_SH, 2, smoothing shift (optional feature only)

Ports:
clk_pix  in  1  pixel clock; sole clock
rst  in  1  synchronous, active-high reset
frame_start  in  1  qualifies first sample of a scan; only meaningful with pwr_valid
pwr_valid  in  1  sample valid
pwr_data  in  PWR_W  power sample, raster order (col fastest)
pwr_ready  out  1  block accepts sample when pwr_valid&pwr_ready
min_pwr  in  PWR_W  detection threshold, sampled in MAP
vsync  in  1  display vsync (active-high), same clock domain
pix_x  out  16  sprite centre x
pix_y  out  16  sprite centre y
spot_valid  out  1  peak_pwr >= min_pwr for the displayed result
peak_pwr  out  PWR_W  peak power of the displayed result
scan_err  out  1  one-cycle pulse: scan restarted before completion

Behaviour:
- Reset (synchronous): pix_x=H_RES/2 (240), pix_y=V_RES/2 (136), spot_valid=0, peak_pwr=0, scan_err=0, pend=0, FSM=IDLE.
- FSM states: IDLE, SCAN, MAP.
- IDLE: pwr_ready=1. A transfer with frame_start=1 loads max=pwr_data, idx=0, cnt=1, then goes to SCAN. Transfers without frame_start are discarded.
- SCAN: pwr_ready=1. Each transfer compares pwr_data > max (strict, so the first occurrence wins ties) and updates max/col/row. col wraps at GRID_W-1 and increments row.
- SCAN exit: on the transfer of sample GRID_W*GRID_H-1, go to MAP.
- SCAN restart: a transfer with frame_start=1 in SCAN restarts the scan with that sample as index 0, pulses scan_err for 1 cycle, and stays in SCAN.
- MAP (1 cycle, pwr_ready=0):
  - x = col*CELL_W + CELL_W/2, y = row*CELL_H + CELL_H/2, computed unsigned at 16 bits.
  - Clamp x to [MARGIN, H_RES-1-MARGIN]; clamp y to [MARGIN, V_RES-1-MARGIN].
  - Load staging regs {x, y, max, max>=min_pwr}; set pend=1; go to IDLE.
- Output update: vsync_d is vsync registered. On vsync & ~vsync_d with pend=1, the outputs take the staging values and pend clears.
  - If the staging hit flag is 0, pix_x/pix_y hold their old values; spot_valid=0 and peak_pwr=staged max.
- Simultaneous vsync edge and MAP write: the outputs take the old staging contents, the staging regs take the new result, and pend stays 1.
- Overwrite before display: a new MAP completes while pend=1. The newer result overwrites staging; the older one is never shown.
- Latency: last sample accepted at cycle N, staging valid at N+1. Outputs change 1 cycle after the first vsync rising edge seen at or after N+2.
- Reset mid-scan: partial max is discarded, FSM goes to IDLE, and outputs return to reset values.

Optional Feature:
HOTSPOT_SMOOTH_EN
- Defined: on each output update with hit=1, pix_x <= pix_x + ((x_stage - pix_x) >>> SMOOTH_SH), and likewise for y.
  - Arithmetic is signed at 17 bits, and the result is re-clamped.
  - First hit after reset loads directly with no smoothing.
- Undefined: direct load as in Behaviour.

Decomposition:
- Package hotspot_pkg:
  - FSM state enum.
  - Default grid/display/MARGIN constants.
  - Derived N_CELLS = GRID_W*GRID_H and index width $clog2(N_CELLS).
- One sub-module, hotspot_argmax: running max, col/row counters and the restart logic. The top level holds MAP, clamp, staging, the vsync edge detector and smoothing.

Test Plan:
- Peak 1000 at col5,row3, all others 10, min_pwr=100, then vsync edge -> pix_x=165, pix_y=105, spot_valid=1, peak_pwr=1000.
- Equal max 500 at index 7 and index 20 -> index 7 wins (col7,row0) -> pix_x=225, pix_y=24 (15 clamped up).
- Peak at col15,row8 -> pix_x=455 (465 clamped), pix_y=247 (255 clamped).
- All samples 50, min_pwr=100, prior spot at (165,105) -> after vsync spot_valid=0, peak_pwr=50, pix_x/pix_y still 165/105.
- frame_start reasserted at sample 40 with the new scan's peak at col2,row1 -> scan_err high exactly 1 cycle; result is pix_x=75, pix_y=45 with no influence from the aborted scan.
- Vsync gating: no vsync for two full scans, then one edge -> outputs change only 1 cycle after the edge and show the second scan. rst asserted mid-scan -> pix_x=240, pix_y=136, spot_valid=0 on the next cycle.
